alu_resp_router: RTL and testbench

- Return-path counterpart to the command priority/dispatch logic in calc1.
- Tracks each of the 4 requester ports from dispatch (ALU1 add/sub, ALU2 shift) to ALU completion.
- Routes each ALU result back to the owning port as a one-cycle response.
- Runs a per-port watchdog so a lost completion still gets a response.

---
 rtl/alu_resp_router_if.sv | 36 +++
 rtl/alu_resp_router.sv | 168 ++++++++++++++++
 tb/tb_alu_resp_router.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_resp_router_if.sv
// Dispatch/completion/response bundle between the ALU return path and alu_resp_router.
// master drives dispatch and completion strobes; slave (the router) drives per-port responses.
interface alu_resp_router_if #(parameter int DATA_W = 32);
  logic              alu1_disp_vld;
  logic [1:0]        alu1_disp_req_id;
  logic              alu2_disp_vld;
  logic [1:0]        alu2_disp_req_id;
  logic              alu1_done_vld;
  logic [1:0]        alu1_done_req_id;
  logic [1:0]        alu1_done_resp;
  logic [DATA_W-1:0] alu1_done_data;
  logic              alu2_done_vld;
  logic [1:0]        alu2_done_req_id;
  logic [1:0]        alu2_done_resp;
  logic [DATA_W-1:0] alu2_done_data;
  logic [1:0]        out_resp1, out_resp2, out_resp3, out_resp4;
  logic [DATA_W-1:0] out_data1, out_data2, out_data3, out_data4;
  logic [3:0]        port_busy;
  logic              prot_err;

  modport master (
    output alu1_disp_vld, alu1_disp_req_id, alu2_disp_vld, alu2_disp_req_id,
           alu1_done_vld, alu1_done_req_id, alu1_done_resp, alu1_done_data,
           alu2_done_vld, alu2_done_req_id, alu2_done_resp, alu2_done_data,
    input  out_resp1, out_resp2, out_resp3, out_resp4,
           out_data1, out_data2, out_data3, out_data4, port_busy, prot_err
  );

  modport slave (
    input  alu1_disp_vld, alu1_disp_req_id, alu2_disp_vld, alu2_disp_req_id,
           alu1_done_vld, alu1_done_req_id, alu1_done_resp, alu1_done_data,
           alu2_done_vld, alu2_done_req_id, alu2_done_resp, alu2_done_data,
    output out_resp1, out_resp2, out_resp3, out_resp4,
           out_data1, out_data2, out_data3, out_data4, port_busy, prot_err
  );
endinterface

// File: rtl/alu_resp_router.sv
// Routes ALU1/ALU2 completions back to the owning requester port as one-cycle responses.
// Define ALU_RESP_ROUTER_TIMEOUT_EN to add a per-port watchdog that answers lost completions with 11.
module alu_resp_router_port #(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic              disp1,
  input  logic              disp2,
  input  logic              done1,
  input  logic              done2,
  input  logic [1:0]        resp1,
  input  logic [1:0]        resp2,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  output logic [1:0]        out_resp,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              err
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("alu_resp_router: TIMEOUT_CYC must be within 2..255");
  end

  state_t            state, state_nx;
  logic [1:0]        hold_resp, hold_resp_nx;
  logic [DATA_W-1:0] hold_data, hold_data_nx;
`ifdef ALU_RESP_ROUTER_TIMEOUT_EN
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] cnt, cnt_nx;
`endif

  always_ff @(negedge c_clk) begin
    if (reset) begin
      state     <= IDLE;
      hold_resp <= '0;
      hold_data <= '0;
`ifdef ALU_RESP_ROUTER_TIMEOUT_EN
      cnt       <= '0;
`endif
    end else begin
      state     <= state_nx;
      hold_resp <= hold_resp_nx;
      hold_data <= hold_data_nx;
`ifdef ALU_RESP_ROUTER_TIMEOUT_EN
      cnt       <= cnt_nx;
`endif
    end
  end

  always_comb begin
    state_nx     = state;
    hold_resp_nx = hold_resp;
    hold_data_nx = hold_data;
    err          = 1'b0;
`ifdef ALU_RESP_ROUTER_TIMEOUT_EN
    cnt_nx       = cnt;
`endif
    if (disp1 && disp2) err = 1'b1;
    if (done1 && done2) err = 1'b1;
    if (done1 && (resp1 == 2'b00 || resp1 == 2'b11)) err = 1'b1;
    if (done2 && (resp2 == 2'b00 || resp2 == 2'b11)) err = 1'b1;
    case (state)
      IDLE: begin
        if (done1 || done2) err = 1'b1;
        if (disp1 || disp2) begin
          state_nx = BUSY;
`ifdef ALU_RESP_ROUTER_TIMEOUT_EN
          cnt_nx   = '0;
`endif
        end
      end
      BUSY: begin
        if (disp1 || disp2) err = 1'b1;
`ifdef ALU_RESP_ROUTER_TIMEOUT_EN
        if (cnt != 8'hFF) cnt_nx = cnt + 8'd1;
`endif
        // ALU1 wins a same-cycle double completion; a real done also beats the watchdog.
        if (done1) begin
          hold_resp_nx = resp1;
          hold_data_nx = data1;
          state_nx     = RESP;
        end else if (done2) begin
          hold_resp_nx = resp2;
          hold_data_nx = data2;
          state_nx     = RESP;
        end
`ifdef ALU_RESP_ROUTER_TIMEOUT_EN
        else if (cnt == CNT_LAST) begin
          hold_resp_nx = 2'b11;
          hold_data_nx = '0;
          state_nx     = RESP;
        end
`endif
      end
      RESP: begin
        if (disp1 || disp2 || done1 || done2) err = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(negedge c_clk) begin
    if (reset) begin
      out_resp <= '0;
      out_data <= '0;
      busy     <= 1'b0;
    end else begin
      busy     <= (state != IDLE);
      out_resp <= (state == RESP) ? hold_resp : 2'b00;
      out_data <= (state == RESP && hold_resp != 2'b00) ? hold_data : '0;
    end
  end
endmodule

module alu_resp_router #(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input logic               c_clk,
  input logic               reset,
  alu_resp_router_if.slave  bus
);
  logic [3:0][1:0]        resp;
  logic [3:0][DATA_W-1:0] data;
  logic [3:0]             busy;
  logic [3:0]             err;
  logic                   prot_err;

  for (genvar i = 0; i < 4; i++) begin : g_port
    alu_resp_router_port #(.DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)) u_port (
      .c_clk    (c_clk),
      .reset    (reset),
      .disp1    (bus.alu1_disp_vld && bus.alu1_disp_req_id == 2'(i)),
      .disp2    (bus.alu2_disp_vld && bus.alu2_disp_req_id == 2'(i)),
      .done1    (bus.alu1_done_vld && bus.alu1_done_req_id == 2'(i)),
      .done2    (bus.alu2_done_vld && bus.alu2_done_req_id == 2'(i)),
      .resp1    (bus.alu1_done_resp),
      .resp2    (bus.alu2_done_resp),
      .data1    (bus.alu1_done_data),
      .data2    (bus.alu2_done_data),
      .out_resp (resp[i]),
      .out_data (data[i]),
      .busy     (busy[i]),
      .err      (err[i])
    );
  end

  always_ff @(negedge c_clk) begin
    if (reset)     prot_err <= 1'b0;
    else if (|err) prot_err <= 1'b1;
  end

  assign bus.out_resp1 = resp[0];
  assign bus.out_resp2 = resp[1];
  assign bus.out_resp3 = resp[2];
  assign bus.out_resp4 = resp[3];
  assign bus.out_data1 = data[0];
  assign bus.out_data2 = data[1];
  assign bus.out_data3 = data[2];
  assign bus.out_data4 = data[3];
  assign bus.port_busy = busy;
  assign bus.prot_err  = prot_err;
endmodule

// File: tb/tb_alu_resp_router.sv
// Directed bench for alu_resp_router: timing-based reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_alu_resp_router;
  localparam int DW = 32;
  localparam int TO = 8;

  logic c_clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  alu_resp_router_if #(.DATA_W(DW)) bus ();
  alu_resp_router #(.DATA_W(DW), .TIMEOUT_CYC(TO)) dut (.c_clk(c_clk), .reset(reset), .bus(bus));

  always #5 c_clk = ~c_clk;

  logic [3:0][1:0]    dut_resp;
  logic [3:0][DW-1:0] dut_data;
  assign dut_resp = {bus.out_resp4, bus.out_resp3, bus.out_resp2, bus.out_resp1};
  assign dut_data = {bus.out_data4, bus.out_data3, bus.out_data2, bus.out_data1};

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, want, $time);
    end
  endtask

  // Reference model: each port remembers when it was dispatched and when it was answered.
  int              edge_n = 0;
  bit              mdl_ready = 0;
  bit              act[4];
  int              disp_e[4], ans_e[4];
  logic [1:0]      ans_r[4];
  logic [DW-1:0]   ans_d[4];
  bit              nonidle[4];
  logic [1:0]      exp_resp[4];
  logic [DW-1:0]   exp_data[4];
  logic [3:0]      exp_busy;
  logic            exp_err;

  always @(negedge c_clk) begin
    bit d1, d2, k1, k2, in_resp;
    edge_n++;
    if (reset) begin
      for (int p = 0; p < 4; p++) begin
        act[p] = 0; disp_e[p] = -100; ans_e[p] = -100; nonidle[p] = 0;
        exp_resp[p] = '0; exp_data[p] = '0;
      end
      exp_busy  = '0;
      exp_err   = 1'b0;
      mdl_ready = 1;
    end else begin
      if (bus.alu1_done_vld && (bus.alu1_done_resp == 2'b00 || bus.alu1_done_resp == 2'b11)) exp_err = 1'b1;
      if (bus.alu2_done_vld && (bus.alu2_done_resp == 2'b00 || bus.alu2_done_resp == 2'b11)) exp_err = 1'b1;
      for (int p = 0; p < 4; p++) begin
        exp_busy[p] = nonidle[p];
        in_resp     = (ans_e[p] == edge_n - 1);
        exp_resp[p] = in_resp ? ans_r[p] : 2'b00;
        exp_data[p] = (in_resp && ans_r[p] != 2'b00) ? ans_d[p] : '0;
        d1 = bus.alu1_disp_vld && bus.alu1_disp_req_id == 2'(p);
        d2 = bus.alu2_disp_vld && bus.alu2_disp_req_id == 2'(p);
        k1 = bus.alu1_done_vld && bus.alu1_done_req_id == 2'(p);
        k2 = bus.alu2_done_vld && bus.alu2_done_req_id == 2'(p);
        if (d1 && d2) exp_err = 1'b1;
        if (k1 && k2) exp_err = 1'b1;
        if (act[p]) begin
          if (d1 || d2) exp_err = 1'b1;
          if (k1) begin
            act[p] = 0; ans_e[p] = edge_n; ans_r[p] = bus.alu1_done_resp; ans_d[p] = bus.alu1_done_data;
          end else if (k2) begin
            act[p] = 0; ans_e[p] = edge_n; ans_r[p] = bus.alu2_done_resp; ans_d[p] = bus.alu2_done_data;
          end
`ifdef ALU_RESP_ROUTER_TIMEOUT_EN
          else if (edge_n - disp_e[p] == TO) begin
            act[p] = 0; ans_e[p] = edge_n; ans_r[p] = 2'b11; ans_d[p] = '0;
          end
`endif
        end else begin
          if (k1 || k2) exp_err = 1'b1;
          if ((d1 || d2) && !in_resp) begin
            act[p] = 1; disp_e[p] = edge_n;
          end else if (d1 || d2) exp_err = 1'b1;
        end
        nonidle[p] = act[p] || (ans_e[p] == edge_n);
      end
    end
  end

  always @(posedge c_clk) begin
    if (mdl_ready) begin
      for (int p = 0; p < 4; p++) begin
        chk($sformatf("out_resp%0d", p + 1), 64'(dut_resp[p]), 64'(exp_resp[p]));
        chk($sformatf("out_data%0d", p + 1), 64'(dut_data[p]), 64'(exp_data[p]));
      end
      chk("port_busy", 64'(bus.port_busy), 64'(exp_busy));
      chk("prot_err", 64'(bus.prot_err), 64'(exp_err));
    end
  end

  task automatic idle_in();
    bus.alu1_disp_vld = 0; bus.alu1_disp_req_id = '0;
    bus.alu2_disp_vld = 0; bus.alu2_disp_req_id = '0;
    bus.alu1_done_vld = 0; bus.alu1_done_req_id = '0; bus.alu1_done_resp = '0; bus.alu1_done_data = '0;
    bus.alu2_done_vld = 0; bus.alu2_done_req_id = '0; bus.alu2_done_resp = '0; bus.alu2_done_data = '0;
  endtask

  task automatic nxt(input int n = 1);
    repeat (n) begin
      @(posedge c_clk); #1;
      idle_in();
    end
  endtask

  task automatic disp(input bit alu2, input logic [1:0] id);
    if (!alu2) begin bus.alu1_disp_vld = 1; bus.alu1_disp_req_id = id; end
    else       begin bus.alu2_disp_vld = 1; bus.alu2_disp_req_id = id; end
  endtask

  task automatic done(input bit alu2, input logic [1:0] id, input logic [1:0] rc, input logic [DW-1:0] d);
    if (!alu2) begin
      bus.alu1_done_vld = 1; bus.alu1_done_req_id = id; bus.alu1_done_resp = rc; bus.alu1_done_data = d;
    end else begin
      bus.alu2_done_vld = 1; bus.alu2_done_req_id = id; bus.alu2_done_resp = rc; bus.alu2_done_data = d;
    end
  endtask

  task automatic do_reset();
    reset = 1; nxt(); reset = 0;
  endtask

  initial begin
    idle_in();
    nxt(2);
    reset = 0;
    chk("reset port_busy", 64'(bus.port_busy), 64'h0);
    chk("reset prot_err", 64'(bus.prot_err), 64'h0);
    nxt();

    // single dispatch, done two cycles later
    disp(0, 2'd1); nxt(2);
    done(0, 2'd1, 2'b01, 32'h5); nxt();
    chk("t1 early resp2", 64'(bus.out_resp2), 64'h0);
    nxt();
    chk("t1 resp2", 64'(bus.out_resp2), 64'h1);
    chk("t1 data2", 64'(bus.out_data2), 64'h5);
    chk("t1 busy during resp", 64'(bus.port_busy[1]), 64'h1);
    nxt();
    chk("t1 resp2 one cycle", 64'(bus.out_resp2), 64'h0);
    chk("t1 busy drop", 64'(bus.port_busy[1]), 64'h0);

    // same-cycle dispatch to ports 1 and 4, dones in reverse order
    disp(0, 2'd0); disp(1, 2'd3); nxt(2);
    done(1, 2'd3, 2'b01, 32'h44); nxt();
    done(0, 2'd0, 2'b01, 32'h11); nxt();
    chk("t2 data4", 64'(bus.out_data4), 64'h44);
    chk("t2 resp1 idle", 64'(bus.out_resp1), 64'h0);
    nxt();
    chk("t2 data1", 64'(bus.out_data1), 64'h11);
    chk("t2 data4 cleared", 64'(bus.out_data4), 64'h0);
    chk("t2 prot_err", 64'(bus.prot_err), 64'h0);

    // done lands exactly on the watchdog cycle
    disp(0, 2'd0); nxt(8);
    done(0, 2'd0, 2'b01, 32'h77); nxt(2);
    chk("t3 edge resp1", 64'(bus.out_resp1), 64'h1);
    chk("t3 edge data1", 64'(bus.out_data1), 64'h77);

    // lost completion on port 3, then a late done
    disp(1, 2'd2); nxt(9);
    chk("t4 resp3 before", 64'(bus.out_resp3), 64'h0);
    nxt();
`ifdef ALU_RESP_ROUTER_TIMEOUT_EN
    chk("t4 timeout resp3", 64'(bus.out_resp3), 64'h3);
    chk("t4 timeout data3", 64'(bus.out_data3), 64'h0);
`else
    chk("t4 still busy", 64'(bus.port_busy[2]), 64'h1);
    done(1, 2'd2, 2'b01, 32'h99); nxt(2);
    chk("t4 late resp3", 64'(bus.out_resp3), 64'h1);
    chk("t4 late data3", 64'(bus.out_data3), 64'h99);
`endif
    done(0, 2'd2, 2'b01, 32'h99); nxt(2);
    chk("t4 late done err", 64'(bus.prot_err), 64'h1);
    chk("t4 late done dropped", 64'(bus.out_resp3), 64'h0);

    // both ALUs complete port 1 together
    do_reset();
    chk("t5 err cleared", 64'(bus.prot_err), 64'h0);
    disp(0, 2'd0); nxt();
    done(0, 2'd0, 2'b01, 32'hA); done(1, 2'd0, 2'b01, 32'hB); nxt(2);
    chk("t5 data1", 64'(bus.out_data1), 64'hA);
    chk("t5 prot_err", 64'(bus.prot_err), 64'h1);

    // dispatch to a busy port is ignored; overflow code forwarded
    do_reset();
    disp(1, 2'd1); nxt();
    disp(0, 2'd1); nxt();
    done(1, 2'd1, 2'b10, 32'hDEAD); nxt(2);
    chk("t6 resp2", 64'(bus.out_resp2), 64'h2);
    chk("t6 data2", 64'(bus.out_data2), 64'hDEAD);
    chk("t6 prot_err", 64'(bus.prot_err), 64'h1);

    // ALU returns code 00: flagged, output data forced to zero
    do_reset();
    disp(0, 2'd2); nxt();
    done(0, 2'd2, 2'b00, 32'h3); nxt();
    chk("t7 prot_err", 64'(bus.prot_err), 64'h1);
    nxt();
    chk("t7 data3", 64'(bus.out_data3), 64'h0);

    // both ALUs dispatch port 1: ALU1 taken, flagged
    do_reset();
    disp(0, 2'd0); disp(1, 2'd0); nxt(2);
    chk("t8 busy1", 64'(bus.port_busy), 64'h1);
    chk("t8 prot_err", 64'(bus.prot_err), 64'h1);
    done(1, 2'd0, 2'b01, 32'h21); nxt(2);
    chk("t8 data1", 64'(bus.out_data1), 64'h21);

    // reset while port 4 is busy
    do_reset();
    disp(1, 2'd3); nxt(2);
    chk("t9 busy4", 64'(bus.port_busy), 64'h8);
    do_reset();
    chk("t9 busy after reset", 64'(bus.port_busy), 64'h0);
    chk("t9 resp4 after reset", 64'(bus.out_resp4), 64'h0);
    chk("t9 err after reset", 64'(bus.prot_err), 64'h0);
    done(0, 2'd3, 2'b01, 32'h55); nxt(2);
    chk("t9 stale done err", 64'(bus.prot_err), 64'h1);
    chk("t9 stale done dropped", 64'(bus.out_resp4), 64'h0);

    nxt(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
